fetch_unit: RTL

- Parametrised instruction-fetch and program-counter block for the RV32I core; next generation of the single-cycle PC.
- Drives a request/acknowledge instruction-memory port and buffers fetched words in a DEPTH-entry FIFO.
- Presents {instruction, PC} pairs to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, flushing buffered and in-flight fetches.

---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 99 +++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/ack port, execute redirect,
// and the decode-side valid/ready port with FIFO occupancy.
interface fetch_unit_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) ();
  logic                       imem_req;
  logic [WIDTH-1:0]           imem_addr;
  logic                       imem_ack;
  logic [31:0]                imem_rdata;
  logic                       redirect;
  logic [WIDTH-1:0]           redirect_addr;
  logic                       dec_valid;
  logic                       dec_ready;
  logic [31:0]                dec_instr;
  logic [WIDTH-1:0]           dec_pc;
  logic [$clog2(DEPTH+1)-1:0] occupancy;

  modport master (
    output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, occupancy,
    input  imem_ack, imem_rdata, redirect, redirect_addr, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, occupancy,
    output imem_ack, imem_rdata, redirect, redirect_addr, dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch / PC block: one outstanding imem request at a time, fetched
// words buffered in a DEPTH-entry FIFO toward decode, redirects flush everything.
module fetch_unit #(
  parameter int               WIDTH        = 32,
  parameter int               DEPTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_KILL = 2'd2;

  typedef struct packed {
    logic [31:0]      instr;
    logic [WIDTH-1:0] pc;
  } ent_t;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] fpc_q, fpc_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] tgt;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    wr_q, rd_q;
  ent_t [DEPTH-1:0] mem_q;
  logic             ack, push, pop;

  assign tgt  = bus.redirect_addr & ~WIDTH'(3);
  assign ack  = bus.imem_ack && (state_q != S_IDLE);
  // An ack in KILL completes the stale request; its data is dropped.
  assign push = ack && (state_q == S_WAIT) && !bus.redirect;
  assign pop  = (count_q != '0) && bus.dec_ready;

  always_comb begin
    fpc_d   = fpc_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (bus.redirect) begin
      fpc_d   = tgt;
      count_d = '0;
    end else if (push) begin
      fpc_d = fpc_q + WIDTH'(4);
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: if (bus.redirect || count_q < CW'(DEPTH)) state_d = S_WAIT;
      S_WAIT: begin
        if (ack) state_d = (bus.redirect || count_d < CW'(DEPTH)) ? S_WAIT : S_IDLE;
        else if (bus.redirect) state_d = S_KILL;
      end
      S_KILL: if (ack) state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
    // The address only moves once the current request is done, so it stays stable under req.
    if (state_q == S_IDLE || ack) addr_d = fpc_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      fpc_q   <= RESET_VECTOR;
      addr_q  <= RESET_VECTOR;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      if (bus.redirect) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + AW'(1);
        if (pop)  rd_q <= rd_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {bus.imem_rdata, addr_q};
  end

  assign bus.imem_req  = (state_q != S_IDLE);
  assign bus.imem_addr = addr_q;
  assign bus.dec_valid = (count_q != '0);
  assign bus.dec_instr = bus.dec_valid ? mem_q[rd_q].instr : '0;
  assign bus.dec_pc    = bus.dec_valid ? mem_q[rd_q].pc : '0;
  assign bus.occupancy = count_q;
endmodule
